// File: rtl/tri_raster_edge.sv
// Edge-function triangle rasterizer: fills one flat-coloured triangle per command
// and streams the covered pixels to the frame buffer over a valid/ready port.
module tri_raster_edge #(
  parameter int unsigned XW        = 11,
  parameter int unsigned SCREEN_W  = 1920,
  parameter int unsigned SCREEN_H  = 1080,
  parameter int unsigned ADDR_W    = 21,
  parameter int unsigned COLOR_W   = 24,
  parameter bit          CULL_BACK = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [XW-1:0]      x0,
  input  logic [XW-1:0]      y0,
  input  logic [XW-1:0]      x1,
  input  logic [XW-1:0]      y1,
  input  logic [XW-1:0]      x2,
  input  logic [XW-1:0]      y2,
  input  logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done,
  output logic               fb_valid,
  input  logic               fb_ready,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic [ADDR_W:0]    pix_count
);

  localparam int unsigned DW = XW + 1;
  localparam int unsigned AW = 2 * XW + 2;
  localparam int unsigned EW = 2 * XW + 3;
  localparam int unsigned CW = ADDR_W + 1;
  localparam logic [XW-1:0] XLIM = XW'(SCREEN_W - 1);
  localparam logic [XW-1:0] YLIM = XW'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP_A, S_SETUP_B, S_SCAN, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0][XW-1:0]   vx_q, vx_d, vy_q, vy_d;
  logic [XW-1:0]        xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
  logic [XW-1:0]        x_q, x_d, y_q, y_d;
  logic signed [EW-1:0] e_q [3];
  logic signed [EW-1:0] e_d [3];
  logic signed [EW-1:0] erow_q [3];
  logic signed [EW-1:0] erow_d [3];
  logic [ADDR_W-1:0]    row_addr_q, row_addr_d, fb_addr_q, fb_addr_d;
  logic [COLOR_W-1:0]   fb_data_q, fb_data_d;
  logic                 fb_valid_q, fb_valid_d, busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]        pix_count_q, pix_count_d;

  function automatic logic signed [DW-1:0] sdiff(input logic [XW-1:0] a,
                                                 input logic [XW-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  // E_ab(p) = (xb-xa)(py-ya) - (yb-ya)(px-xa)
  function automatic logic signed [EW-1:0] edge_at(input logic [XW-1:0] xa,
                                                   input logic [XW-1:0] ya,
                                                   input logic [XW-1:0] xb,
                                                   input logic [XW-1:0] yb,
                                                   input logic [XW-1:0] px,
                                                   input logic [XW-1:0] py);
    return EW'(sdiff(xb, xa)) * EW'(sdiff(py, ya)) - EW'(sdiff(yb, ya)) * EW'(sdiff(px, xa));
  endfunction

  function automatic logic [XW-1:0] min3(input logic [2:0][XW-1:0] v);
    logic [XW-1:0] m;
    m = (v[0] < v[1]) ? v[0] : v[1];
    return (v[2] < m) ? v[2] : m;
  endfunction

  function automatic logic [XW-1:0] max3(input logic [2:0][XW-1:0] v);
    logic [XW-1:0] m;
    m = (v[0] > v[1]) ? v[0] : v[1];
    return (v[2] > m) ? v[2] : m;
  endfunction

  logic signed [AW-1:0] area;
  logic [XW-1:0]        xmin_c, ymin_c, xhi, yhi, xmax_c, ymax_c;
  logic                 bb_empty;
  logic signed [EW-1:0] e_init [3];
  logic signed [EW-1:0] step_x [3];
  logic signed [EW-1:0] step_y [3];
  logic signed [EW-1:0] e_nx [3];
  logic signed [EW-1:0] e_ny [3];
  logic                 in_init, in_nx, in_ny, advance, row_end, last_px;

  assign area = AW'(sdiff(vx_q[1], vx_q[0])) * AW'(sdiff(vy_q[2], vy_q[0]))
              - AW'(sdiff(vx_q[2], vx_q[0])) * AW'(sdiff(vy_q[1], vy_q[0]));

  // Bounding box clipped to the screen; coordinates are unsigned so only the top is clipped.
  assign xmin_c   = min3(vx_q);
  assign ymin_c   = min3(vy_q);
  assign xhi      = max3(vx_q);
  assign yhi      = max3(vy_q);
  assign xmax_c   = (xhi > XLIM) ? XLIM : xhi;
  assign ymax_c   = (yhi > YLIM) ? YLIM : yhi;
  assign bb_empty = (xmin_c > XLIM) || (ymin_c > YLIM);

  for (genvar k = 0; k < 3; k++) begin : g_edge
    localparam int unsigned B = (k + 1) % 3;
    assign e_init[k] = edge_at(vx_q[k], vy_q[k], vx_q[B], vy_q[B], xmin_c, ymin_c);
    assign step_x[k] = EW'(sdiff(vy_q[k], vy_q[B]));
    assign step_y[k] = EW'(sdiff(vx_q[B], vx_q[k]));
    assign e_nx[k]   = e_q[k] + step_x[k];
    assign e_ny[k]   = erow_q[k] + step_y[k];
  end

  assign in_init = ~(e_init[0][EW-1] | e_init[1][EW-1] | e_init[2][EW-1]);
  assign in_nx   = ~(e_nx[0][EW-1] | e_nx[1][EW-1] | e_nx[2][EW-1]);
  assign in_ny   = ~(e_ny[0][EW-1] | e_ny[1][EW-1] | e_ny[2][EW-1]);
  assign advance = ~fb_valid_q | fb_ready;
  assign row_end = (x_q == xmax_q);
  assign last_px = row_end && (y_q == ymax_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_SETUP_A;
      S_SETUP_A: state_d = ((area == '0) || (CULL_BACK && area[AW-1])) ? S_DONE : S_SETUP_B;
      S_SETUP_B: state_d = bb_empty ? S_DONE : S_SCAN;
      S_SCAN:    if (advance && last_px) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vx_d        = vx_q;
    vy_d        = vy_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymax_d      = ymax_q;
    x_d         = x_q;
    y_d         = y_q;
    e_d         = e_q;
    erow_d      = erow_q;
    row_addr_d  = row_addr_q;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;
    fb_valid_d  = fb_valid_q;
    pix_count_d = pix_count_q;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    unique case (state_q)
      S_IDLE: if (start) begin
        vx_d        = {x2, x1, x0};
        vy_d        = {y2, y1, y0};
        fb_data_d   = color;
        pix_count_d = '0;
      end
      // Clockwise input is rewound so every later stage sees positive area.
      S_SETUP_A: if (area[AW-1] && !CULL_BACK) begin
        vx_d[1] = vx_q[2];
        vx_d[2] = vx_q[1];
        vy_d[1] = vy_q[2];
        vy_d[2] = vy_q[1];
      end
      S_SETUP_B: begin
        xmin_d     = xmin_c;
        xmax_d     = xmax_c;
        ymax_d     = ymax_c;
        x_d        = xmin_c;
        y_d        = ymin_c;
        e_d        = e_init;
        erow_d     = e_init;
        row_addr_d = ADDR_W'(ymin_c) * ADDR_W'(SCREEN_W) + ADDR_W'(xmin_c);
        fb_addr_d  = ADDR_W'(ymin_c) * ADDR_W'(SCREEN_W) + ADDR_W'(xmin_c);
        fb_valid_d = !bb_empty && in_init;
      end
      S_SCAN: if (advance) begin
        if (fb_valid_q) pix_count_d = pix_count_q + CW'(1);
        if (last_px) begin
          fb_valid_d = 1'b0;
        end else if (row_end) begin
          x_d        = xmin_q;
          y_d        = y_q + XW'(1);
          e_d        = e_ny;
          erow_d     = e_ny;
          row_addr_d = row_addr_q + ADDR_W'(SCREEN_W);
          fb_addr_d  = row_addr_q + ADDR_W'(SCREEN_W);
          fb_valid_d = in_ny;
        end else begin
          x_d        = x_q + XW'(1);
          e_d        = e_nx;
          fb_addr_d  = fb_addr_q + ADDR_W'(1);
          fb_valid_d = in_nx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vx_q        <= '0;
      vy_q        <= '0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymax_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      for (int k = 0; k < 3; k++) begin
        e_q[k]    <= '0;
        erow_q[k] <= '0;
      end
      row_addr_q  <= '0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      fb_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_count_q <= '0;
    end else begin
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymax_q      <= ymax_d;
      x_q         <= x_d;
      y_q         <= y_d;
      e_q         <= e_d;
      erow_q      <= erow_d;
      row_addr_q  <= row_addr_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      fb_valid_q  <= fb_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pix_count_q <= pix_count_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fb_valid  = fb_valid_q;
  assign fb_addr   = fb_addr_q;
  assign fb_data   = fb_data_q;
  assign pix_count = pix_count_q;

endmodule

// File: tb/tb_tri_raster_edge.sv
// Directed bench for tri_raster_edge: one default instance and one with back-face culling,
// sharing all inputs; a select picks which one the command runner observes.
module tb_tri_raster_edge;

  localparam int unsigned XW = 11;
  localparam int unsigned AW = 21;
  localparam int unsigned CW = 24;
  localparam int unsigned SW = 1920;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          fb_ready = 1'b1;
  logic [XW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic [CW-1:0] color = '0;

  logic          busy0, done0, val0, busy1, done1, val1;
  logic [AW-1:0] addr0, addr1;
  logic [CW-1:0] data0, data1;
  logic [AW:0]   cnt0, cnt1;

  logic          sel = 1'b0;
  logic          o_busy, o_done, o_valid;
  logic [AW-1:0] o_addr;
  logic [CW-1:0] o_data;
  logic [AW:0]   o_cnt;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            done_cyc;
  int unsigned   got_addr[$];
  logic [CW-1:0] got_data[$];
  int unsigned   exp_addr[$];

  tri_raster_edge #(.XW(XW), .SCREEN_W(SW), .SCREEN_H(1080), .ADDR_W(AW), .COLOR_W(CW),
                    .CULL_BACK(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .color(color),
    .busy(busy0), .done(done0), .fb_valid(val0), .fb_ready(fb_ready),
    .fb_addr(addr0), .fb_data(data0), .pix_count(cnt0)
  );

  tri_raster_edge #(.XW(XW), .SCREEN_W(SW), .SCREEN_H(1080), .ADDR_W(AW), .COLOR_W(CW),
                    .CULL_BACK(1'b1)) dut_cull (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .color(color),
    .busy(busy1), .done(done1), .fb_valid(val1), .fb_ready(fb_ready),
    .fb_addr(addr1), .fb_data(data1), .pix_count(cnt1)
  );

  always #5 clk = ~clk;

  always_comb begin
    o_busy  = sel ? busy1 : busy0;
    o_done  = sel ? done1 : done0;
    o_valid = sel ? val1  : val0;
    o_addr  = sel ? addr1 : addr0;
    o_data  = sel ? data1 : data0;
    o_cnt   = sel ? cnt1  : cnt0;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected pixels of the (0,0),(4,0),(0,4) triangle: x+y <= 4, row-major.
  task automatic build_basic();
    exp_addr.delete();
    for (int y = 0; y <= 4; y++)
      for (int x = 0; x <= 4 - y; x++)
        exp_addr.push_back(y * SW + x);
  endtask

  // Expected pixels of the (1918,0),(1925,0),(1918,7) triangle after clipping at x=1919.
  task automatic build_clip();
    exp_addr.delete();
    for (int y = 0; y <= 7; y++)
      for (int x = 1918; x <= 1919; x++)
        if ((x - 1918) + y <= 7) exp_addr.push_back(y * SW + x);
  endtask

  task automatic check_writes(input string tag, input logic [CW-1:0] col, input int cnt_exp);
    check_eq($sformatf("%s_nwrites", tag), 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < got_addr.size()) begin
        check_eq($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
        check_eq($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(col));
      end
    end
    check_eq($sformatf("%s_pixcount", tag), 64'(o_cnt), 64'(cnt_exp));
  endtask

  // mode: 0 ready high, 1 ready alternating, 2 random ready. poke: cycle to fire a stray start.
  task automatic run_cmd(input logic [XW-1:0] ax, input logic [XW-1:0] ay,
                         input logic [XW-1:0] bx, input logic [XW-1:0] by,
                         input logic [XW-1:0] cx, input logic [XW-1:0] cy,
                         input logic [CW-1:0] col, input int mode, input int poke);
    logic              stalled;
    logic [AW+CW-1:0]  held;
    got_addr.delete();
    got_data.delete();
    done_cyc = -1;
    @(negedge clk);
    x0 = ax; y0 = ay; x1 = bx; y1 = by; x2 = cx; y2 = cy;
    color = col; start = 1'b1; fb_ready = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    stalled = 1'b0;
    held    = '0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (cyc == 1) check_eq("busy_after_start", 64'(o_busy), 64'(1));
      if (stalled) begin
        check_eq("stall_valid", 64'(o_valid), 64'(1));
        check_eq("stall_addr_data", 64'({o_addr, o_data}), 64'(held));
      end
      if (o_done) begin
        done_cyc = cyc;
        break;
      end
      case (mode)
        1:       fb_ready = cyc[0];
        2:       fb_ready = 1'($urandom_range(0, 1));
        default: fb_ready = 1'b1;
      endcase
      if (o_valid && fb_ready) begin
        got_addr.push_back(32'(o_addr));
        got_data.push_back(o_data);
      end
      stalled = o_valid & ~fb_ready;
      held    = {o_addr, o_data};
      start   = (cyc == poke);
      if (cyc == poke) begin
        x1 = 11'd2; y1 = 11'd2; x2 = 11'd4; y2 = 11'd4; color = 24'h00FF00;
      end
      @(negedge clk);
    end
    start    = 1'b0;
    fb_ready = 1'b1;
    check_eq("done_seen", 64'(o_done), 64'(1));
    @(negedge clk);
    check_eq("done_one_cycle", 64'(o_done), 64'(0));
    check_eq("busy_after_done", 64'(o_busy), 64'(0));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_reached", 64'({busy0, busy1}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values on both instances.
    repeat (2) @(negedge clk);
    check_eq("rst_busy",  64'({busy0, busy1}), 64'(0));
    check_eq("rst_done",  64'({done0, done1}), 64'(0));
    check_eq("rst_valid", 64'({val0, val1}), 64'(0));
    check_eq("rst_addr",  64'({addr0, addr1}), 64'(0));
    check_eq("rst_data",  64'({data0, data1}), 64'(0));
    check_eq("rst_cnt",   64'({cnt0, cnt1}), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Basic fill.
    sel = 1'b0;
    build_basic();
    run_cmd(0, 0, 4, 0, 0, 4, 24'hFF0000, 0, 0);
    check_eq("basic_done_cyc", 64'(done_cyc), 64'(28));
    check_writes("basic", 24'hFF0000, 15);

    // Clockwise winding is rewound on the default instance.
    run_cmd(0, 0, 0, 4, 4, 0, 24'h123456, 0, 0);
    check_eq("wind_done_cyc", 64'(done_cyc), 64'(28));
    check_writes("wind", 24'h123456, 15);

    // Same winding is culled on the CULL_BACK instance.
    sel = 1'b1;
    exp_addr.delete();
    run_cmd(0, 0, 0, 4, 4, 0, 24'h123456, 0, 0);
    check_eq("cull_done_cyc", 64'(done_cyc), 64'(2));
    check_writes("cull", 24'h123456, 0);
    wait_idle();
    sel = 1'b0;

    // Degenerate (collinear) triangle.
    exp_addr.delete();
    run_cmd(0, 0, 2, 2, 4, 4, 24'hABCDEF, 0, 0);
    check_eq("degen_done_cyc", 64'(done_cyc), 64'(2));
    check_writes("degen", 24'hABCDEF, 0);
    wait_idle();

    // Stray start while busy is ignored.
    build_basic();
    run_cmd(0, 0, 4, 0, 0, 4, 24'hFF0000, 0, 10);
    check_eq("poke_done_cyc", 64'(done_cyc), 64'(28));
    check_writes("poke", 24'hFF0000, 15);
    wait_idle();

    // Backpressure: alternating then random ready.
    run_cmd(0, 0, 4, 0, 0, 4, 24'h0000FF, 1, 0);
    check_writes("bp_alt", 24'h0000FF, 15);
    wait_idle();
    run_cmd(0, 0, 4, 0, 0, 4, 24'h00FFFF, 2, 0);
    check_writes("bp_rand", 24'h00FFFF, 15);
    wait_idle();

    // Clipping at the right screen edge.
    build_clip();
    run_cmd(1918, 0, 1925, 0, 1918, 7, 24'h808080, 0, 0);
    check_eq("clip_done_cyc", 64'(done_cyc), 64'(19));
    check_writes("clip", 24'h808080, 15);
    wait_idle();

    // Reset during the 5th pixel with the frame buffer stalled.
    @(negedge clk);
    x0 = 0; y0 = 0; x1 = 4; y1 = 0; x2 = 0; y2 = 4;
    color = 24'hFF0000; start = 1'b1; fb_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    fb_ready = 1'b0;
    check_eq("pre_rst_valid", 64'(o_valid), 64'(1));
    check_eq("pre_rst_addr", 64'(o_addr), 64'(4));
    check_eq("pre_rst_cnt", 64'(o_cnt), 64'(4));
    #1 reset = 1'b1;
    #1;
    check_eq("mid_rst_busy", 64'(o_busy), 64'(0));
    check_eq("mid_rst_done", 64'(o_done), 64'(0));
    check_eq("mid_rst_valid", 64'(o_valid), 64'(0));
    check_eq("mid_rst_addr", 64'(o_addr), 64'(0));
    check_eq("mid_rst_data", 64'(o_data), 64'(0));
    check_eq("mid_rst_cnt", 64'(o_cnt), 64'(0));
    @(negedge clk);
    reset    = 1'b0;
    fb_ready = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy", 64'(o_busy), 64'(0));
    check_eq("post_rst_valid", 64'(o_valid), 64'(0));
    build_basic();
    run_cmd(0, 0, 4, 0, 0, 4, 24'hFF0000, 0, 0);
    check_eq("after_rst_done_cyc", 64'(done_cyc), 64'(28));
    check_writes("after_rst", 24'hFF0000, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tri_raster_edge.md
# tri_raster_edge

Parametrised edge-function triangle rasterizer: fills one flat-coloured triangle per command and replaces the fixed 1920-wide scanline filler in the render pipeline. It sits between the command decoder and the frame-buffer write port. Over the previous block it adds:
- screen-size, coordinate and colour width generics
- winding normalisation with optional back-face culling
- degenerate-triangle rejection and screen clipping
- a valid/ready frame-buffer handshake with backpressure
- a written-pixel counter

## Interface
- XW, 11, coordinate width (unsigned x/y)
- SCREEN_W, 1920, pixels per row; fb_addr = y*SCREEN_W + x
- SCREEN_H, 1080, rows
- ADDR_W, 21, frame-buffer address width
- COLOR_W, 24, pixel data width
- CULL_BACK, 0, 1 = discard negative-area (clockwise) triangles
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- start  in  1  command strobe, accepted only when busy=0
- x0,y0,x1,y1,x2,y2  in  XW each  vertex coordinates, captured on accepted start
- color  in  COLOR_W  flat fill colour, captured on accepted start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at command completion
- fb_valid  out  1  pixel write request
- fb_ready  in  1  frame buffer accepts the write when fb_valid & fb_ready
- fb_addr  out  ADDR_W  write address
- fb_data  out  COLOR_W  write data (captured colour)
- pix_count  out  ADDR_W+1  pixels written by current/last command; cleared on accepted start

## Operation
- States: IDLE, SETUP_A, SETUP_B, SCAN, DONE.
- IDLE:
  - start=1 latches vertices and colour, clears pix_count, then goes to SETUP_A.
  - start while busy is ignored; no queueing.
- SETUP_A: computes signed area A = (x1-x0)(y2-y0) - (x2-x0)(y1-y0) at 2*XW+2 bits.
  - A==0 -> DONE.
  - A<0 and CULL_BACK=1 -> DONE.
  - A<0 and CULL_BACK=0 -> swap v1/v2 internally, so A>0 from here on.
- SETUP_B:
  - Bounding box = min/max of vertices, clipped to [0,SCREEN_W-1] x [0,SCREEN_H-1]. An empty box (xmin>SCREEN_W-1 or ymin>SCREEN_H-1) -> DONE.
  - Initialises edge functions at (xmin,ymin): E_ab(p) = (xb-xa)(py-ya) - (yb-ya)(px-xa) for edges 01, 12, 20.
  - Edge accumulators are signed, 2*XW+3 bits; they cannot overflow.
- SCAN: visits bbox pixels row-major, x fastest.
  - Stepping is incremental, adds only: x+1 adds -(yb-ya); a new row reloads row-start E plus (xb-xa).
  - Pixel is inside iff all three E >= 0. Edge pixels are inclusive, so shared edges are drawn by both neighbours.
  - Outside pixel: advance next cycle, no write.
  - Inside pixel: fb_valid=1 with fb_addr = y*SCREEN_W + x and fb_data = colour. Advance and increment pix_count on the handshake cycle.
  - After the last bbox pixel, go to DONE.
- DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE. pix_count holds until the next accepted start.

## Timing
- Reset values: busy=0, done=0, fb_valid=0, fb_addr=0, fb_data=0, pix_count=0, state IDLE. Reset takes effect immediately, including mid-SCAN. An in-flight write is abandoned (fb_valid drops without handshake) and the command is lost.
- Start accepted at edge T: SETUP_A in T+1, SETUP_B in T+2, first SCAN pixel evaluated in T+3.
- Early termination (degenerate, culled or empty bbox): done pulses in T+2 (from SETUP_A) or T+3 (from SETUP_B).
- SCAN costs 1 cycle per outside pixel and 1 + (fb_ready-low cycles) per inside pixel. With fb_ready tied high, done = T + 3 + bbox_pixels.
- While fb_valid=1 and fb_ready=0, fb_addr and fb_data are held stable and fb_valid stays high. fb_valid never depends combinationally on fb_ready.
- All outputs are registered. done and the final write handshake never coincide; done follows the last SCAN cycle.

## Test plan
- Basic fill: (0,0),(4,0),(0,4), colour 0xFF0000, fb_ready=1 -> exactly 15 writes at addr y*1920+x for x+y<=4. pix_count=15; done 28 cycles after the start edge.
- Winding: v1/v2 swapped, CULL_BACK=0 -> the same 15 addresses in the same order. With CULL_BACK=1 -> zero writes, done at T+2, pix_count=0.
- Degenerate: (0,0),(2,2),(4,4) -> no fb_valid, done at T+2. A start asserted while busy during another command is ignored.
- Backpressure: basic-fill triangle with fb_ready alternating 1/0 and random stalls -> addr/data stable during stalls, 15 unique writes, no duplicates, pix_count=15.
- Clipping: (1918,0),(1925,0),(1918,7) -> writes only x in {1918,1919}: 8 pixels at x=1918 (y 0..7) and 7 at x=1919 (y 0..6). pix_count=15; no address >= row*1920+1920.
- Reset mid-SCAN: reset asserted during the 5th pixel with fb_ready=0 -> all outputs 0 immediately, IDLE. A new start afterwards completes normally.
